fp_sub_arbiter: RTL
===================

Name: fp_sub_arbiter

Overview:
- Shares one combinational single-precision subtract unit (z = a - b, same-sign operands) among NREQ requesters.
- Round-robin arbiter feeds a 2-stage registered pipeline: operand register (S1) → subtract unit → result register (S2).
- Results are returned on one tagged output channel with valid/ready backpressure.
- Sits between FFT butterfly sequencers and the shared FP subtract datapath.

Parameters:
- NREQ, 4: number of requesters (2..8).
- IDW, 2: requester-id width; must satisfy 2**IDW >= NREQ.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester operand-valid.
- req_ready  out  NREQ  per-requester accept (one-hot or zero).
- req_a  in  32*NREQ  minuend, requester i at bits [32i+31:32i].
- req_b  in  32*NREQ  subtrahend, same packing.
- res_valid  out  1  result valid.
- res_ready  in  1  consumer accept.
- res_z  out  32  a - b, SP float.
- res_id  out  IDW  index of the originating requester.
- busy  out  1  S1 or S2 occupied.

Behaviour:
- Reset (synchronous, active-high): S1/S2 valid=0, res_valid=0, res_z=0, res_id=0, RR pointer=0, busy=0, req_ready=0.
- Reset mid-operation: all in-flight operations are discarded; no result is emitted for them.
- Handshakes: a transfer occurs when valid & ready are both high on a clk edge.
  - req_valid must hold with stable operands until accepted.
  - res_* hold stable while res_valid & !res_ready.
- Advance conditions:
  - s2_adv = !s2_v | res_ready.
  - s1_adv = s1_v & s2_adv.
  - s1_free = !s1_v | s1_adv.
- Arbitration:
  - When s1_free, grant the first req_valid[i] searching from ptr upward, wrapping modulo NREQ.
  - req_ready = one-hot of grant; zero when !s1_free or no request.
  - On grant of i: ptr ← (i+1) mod NREQ. With no grant, ptr is unchanged.
  - req_ready is combinational from req_valid/ptr/pipeline state; no combinational path from req_a/req_b.
- S1: on grant, latch a, b, id; s1_v←1. Else if s1_adv, s1_v←0.
- S2: if s1_adv, latch z=sub(S1.a, S1.b), id, s2_v←1. Else if res_ready, s2_v←0.
  - Simultaneous S2 drain and S1 advance: S2 reloads; res_valid stays high.
- Latency and throughput:
  - Accept → res_valid exactly 2 cycles with no backpressure.
  - Sustained throughput is 1 result/cycle.
  - Full backpressure holds at most 2 operations in flight; req_ready=0 while both stages are full and res_ready=0.
- Ordering: results leave in grant order.
- Subtract function:
  - Identical operands → +0 (0x00000000).
  - Zero operand or exponent difference >22 → passes the larger operand (negated if it is b).
  - Otherwise the result sign is a's sign if a > b as unsigned words, else inverted.
  - Behaviour for mixed-sign operands is undefined unless the optional feature is enabled.
- busy = s1_v | s2_v.

Optional Feature:
- Macro: FP_SUB_ARB_SIGN_CHECK_EN.
- Defined:
  - Adds output port res_err (1 bit), registered alongside res_z; reset value 0.
  - res_err=1 when the latched operands' sign bits differ.
  - res_z is forced to 0xFFFFFFFF (NaN) for that result.
  - The handshake is unchanged.
- Undefined: no res_err port; res_z is the raw subtract-unit output for every operand pair.

Test Plan:
- Single request, no backpressure: req0 a=0x40400000 (3.0), b=0x3F800000 (1.0), res_ready=1 → res_valid 2 cycles after accept, res_z=0x40000000, res_id=0.
- Reversed operands: req2 a=0x3F800000, b=0x40400000 → res_z=0xC0000000 (-2.0), res_id=2; equal operands a=b=0x40A00000 → res_z=0x00000000.
- Round-robin fairness: all 4 req_valid held high for 8 cycles, res_ready=1 → grants 0,1,2,3,0,1,2,3; res_id follows the same order; one result/cycle after 2-cycle fill.
- Backpressure: stream on req1 with res_ready=0 from cycle 3 → at most 2 accepted, req_ready=0, res_z/res_id stable. Release res_ready → no loss or duplication, order preserved; 0x40A00000-0x40000000 yields 0x40400000.
- Reset mid-stream: assert reset 1 cycle while S1 and S2 are full → next cycle res_valid=0, busy=0, ptr=0; a subsequent single request from req3 is granted and completes normally.
- With FP_SUB_ARB_SIGN_CHECK_EN: a=0x3F800000, b=0xBF800000 → res_err=1, res_z=0xFFFFFFFF. Same-sign pair → res_err=0.

Source files
------------

// File: rtl/fp_sub_arbiter.sv
// Round-robin share of one same-sign SP subtract (z = a - b) across NREQ requesters.
// Latency: 2 cycles, accept to res_valid (operand reg S1, result reg S2); 1 result/cycle sustained.
// Backpressure: res_ready low stalls S2 then S1, and req_ready drops. FP_SUB_ARB_SIGN_CHECK_EN adds res_err.
module fp_sub_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [31:0]          res_z,
    output logic [IDW-1:0]       res_id,
    output logic                 busy
`ifdef FP_SUB_ARB_SIGN_CHECK_EN
    ,
    output logic                 res_err
`endif
);

    logic            s1_v_q, s1_v_d;
    logic [31:0]     s1_a_q, s1_a_d;
    logic [31:0]     s1_b_q, s1_b_d;
    logic [IDW-1:0]  s1_id_q, s1_id_d;
    logic            s2_v_q, s2_v_d;
    logic [31:0]     s2_z_q, s2_z_d;
    logic [IDW-1:0]  s2_id_q, s2_id_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
`ifdef FP_SUB_ARB_SIGN_CHECK_EN
    logic            s2_err_q, s2_err_d;
`endif

    logic            s2_adv, s1_adv, s1_free;
    logic            gnt_vld, grant;
    logic [IDW-1:0]  gnt_idx;
    logic [IDW:0]    cand;
    logic [NREQ-1:0] rot_vld;

    assign s2_adv  = !s2_v_q || res_ready;
    assign s1_adv  = s1_v_q && s2_adv;
    assign s1_free = !s1_v_q || s1_adv;

    // Rotate the requests so bit 0 is the pointer slot, then map the first hit back.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        rot_vld = NREQ'({req_valid, req_valid} >> ptr_q);
        for (int k = 0; k < NREQ; k++) begin
            if (!gnt_vld && rot_vld[k]) begin
                gnt_vld = 1'b1;
                cand    = {1'b0, ptr_q} + (IDW+1)'(k);
                if (cand >= (IDW+1)'(NREQ)) begin
                    cand = cand - (IDW+1)'(NREQ);
                end
                gnt_idx = cand[IDW-1:0];
            end
        end
    end

    assign grant     = gnt_vld && s1_free;
    assign req_ready = grant ? (NREQ'(1) << gnt_idx) : '0;

    // Same-sign subtract: exact 48-bit magnitude difference, normalise, round to nearest even.
    // Exponent-zero operands are treated as zero; results below the normal range flush to +0.
    logic        a_gt_b, sub_sign, lz_found, rnd_up;
    logic [7:0]  ea, eb, e_big, e_sml, ediff, e_res;
    logic [23:0] m_big, m_sml;
    logic [47:0] al_big, al_sml, diff, norm;
    logic [5:0]  lz;
    logic [24:0] mant_r;
    logic [31:0] sub_z;

    always_comb begin
        a_gt_b   = s1_a_q[30:0] > s1_b_q[30:0];
        ea       = s1_a_q[30:23];
        eb       = s1_b_q[30:23];
        sub_sign = a_gt_b ? s1_a_q[31] : ~s1_a_q[31];
        if (a_gt_b) begin
            e_big = ea;
            e_sml = eb;
            m_big = {1'b1, s1_a_q[22:0]};
            m_sml = {1'b1, s1_b_q[22:0]};
        end else begin
            e_big = eb;
            e_sml = ea;
            m_big = {1'b1, s1_b_q[22:0]};
            m_sml = {1'b1, s1_a_q[22:0]};
        end
        ediff    = e_big - e_sml;
        al_big   = {m_big, 24'd0};
        al_sml   = {m_sml, 24'd0} >> ediff;
        diff     = al_big - al_sml;
        lz       = '0;
        lz_found = 1'b0;
        for (int i = 47; i >= 0; i--) begin
            if (!lz_found && diff[i]) begin
                lz       = 6'(47 - i);
                lz_found = 1'b1;
            end
        end
        norm   = diff << lz;
        rnd_up = norm[23] && ((|norm[22:0]) || norm[24]);
        mant_r = {1'b0, norm[47:24]} + {24'd0, rnd_up};
        e_res  = e_big - {2'b0, lz} + {7'd0, mant_r[24]};

        if (s1_a_q == s1_b_q) begin
            sub_z = 32'h0000_0000;
        end else if (ea == 8'd0 || eb == 8'd0 || ediff > 8'd22) begin
            sub_z = a_gt_b ? s1_a_q : {~s1_b_q[31], s1_b_q[30:0]};
        end else if (!lz_found || {2'b0, lz} >= e_big) begin
            sub_z = 32'h0000_0000;
        end else begin
            sub_z = {sub_sign, e_res, mant_r[24] ? mant_r[23:1] : mant_r[22:0]};
        end
    end

    always_comb begin
        ptr_d   = ptr_q;
        s1_v_d  = s1_v_q;
        s1_a_d  = s1_a_q;
        s1_b_d  = s1_b_q;
        s1_id_d = s1_id_q;
        s2_v_d  = s2_v_q;
        s2_z_d  = s2_z_q;
        s2_id_d = s2_id_q;
`ifdef FP_SUB_ARB_SIGN_CHECK_EN
        s2_err_d = s2_err_q;
`endif
        if (grant) begin
            s1_v_d  = 1'b1;
            s1_a_d  = req_a[32*gnt_idx +: 32];
            s1_b_d  = req_b[32*gnt_idx +: 32];
            s1_id_d = gnt_idx;
            ptr_d   = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
        end else if (s1_adv) begin
            s1_v_d = 1'b0;
        end

        if (s1_adv) begin
            s2_v_d  = 1'b1;
            s2_id_d = s1_id_q;
`ifdef FP_SUB_ARB_SIGN_CHECK_EN
            s2_err_d = s1_a_q[31] ^ s1_b_q[31];
            s2_z_d   = (s1_a_q[31] ^ s1_b_q[31]) ? 32'hFFFF_FFFF : sub_z;
`else
            s2_z_d   = sub_z;
`endif
        end else if (res_ready) begin
            s2_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q   <= '0;
            s1_v_q  <= 1'b0;
            s1_a_q  <= '0;
            s1_b_q  <= '0;
            s1_id_q <= '0;
            s2_v_q  <= 1'b0;
            s2_z_q  <= '0;
            s2_id_q <= '0;
`ifdef FP_SUB_ARB_SIGN_CHECK_EN
            s2_err_q <= 1'b0;
`endif
        end else begin
            ptr_q   <= ptr_d;
            s1_v_q  <= s1_v_d;
            s1_a_q  <= s1_a_d;
            s1_b_q  <= s1_b_d;
            s1_id_q <= s1_id_d;
            s2_v_q  <= s2_v_d;
            s2_z_q  <= s2_z_d;
            s2_id_q <= s2_id_d;
`ifdef FP_SUB_ARB_SIGN_CHECK_EN
            s2_err_q <= s2_err_d;
`endif
        end
    end

    assign res_valid = s2_v_q;
    assign res_z     = s2_z_q;
    assign res_id    = s2_id_q;
    assign busy      = s1_v_q || s2_v_q;
`ifdef FP_SUB_ARB_SIGN_CHECK_EN
    assign res_err   = s2_err_q;
`endif

endmodule
